// File: rtl/buart_pkg.sv
// Shared types and frame constants for the buart 8N1 transceiver.
package buart_pkg;

  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned FRAME_BITS = 10;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  function automatic int unsigned calc_clks_per_bit(input int unsigned clk_hz,
                                                    input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/inpin.sv
// Two-flop metastability synchronizer for an asynchronous input pin.
module inpin (
  input  logic clk,
  input  logic pin,
  output logic rd
);

  logic meta;

  always_ff @(posedge clk) begin
    meta <= pin;
    rd   <= meta;
  end

endmodule

// File: rtl/buart.sv
// 8N1 UART transceiver: registered RX holding byte, single-shot TX.
// BUART_RX_SYNC_EN selects a two-flop rx synchronizer (inpin) instead of one register.
module buart
  import buart_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 12000000,
  parameter int unsigned BAUD         = 115200,
  parameter int unsigned CLKS_PER_BIT = calc_clks_per_bit(CLK_HZ, BAUD)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic                 tx,
  input  logic                 rd,
  input  logic                 wr,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 valid,
  output logic                 busy
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

  // ---------------- transmitter ----------------
  tx_state_e            tx_state, tx_state_n;
  logic [CW-1:0]        tx_cnt, tx_cnt_n;
  logic [2:0]           tx_idx, tx_idx_n;
  logic [DATA_BITS-1:0] tx_shift, tx_shift_n;
  logic                 tx_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      tx       <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_idx   <= tx_idx_n;
      tx_shift <= tx_shift_n;
      tx       <= tx_n;
    end
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt + CW'(1);
    tx_idx_n   = tx_idx;
    tx_shift_n = tx_shift;
    tx_n       = tx;
    unique case (tx_state)
      TX_IDLE: begin
        tx_cnt_n = '0;
        tx_n     = 1'b1;
        if (wr) begin
          tx_shift_n = tx_data;
          tx_state_n = TX_START;
          tx_n       = 1'b0;
        end
      end
      TX_START: if (tx_cnt == BIT_END) begin
        tx_cnt_n   = '0;
        tx_idx_n   = '0;
        tx_state_n = TX_DATA;
        tx_n       = tx_shift[0];
      end
      TX_DATA: if (tx_cnt == BIT_END) begin
        tx_cnt_n = '0;
        if (tx_idx == LAST_BIT) begin
          tx_state_n = TX_STOP;
          tx_n       = 1'b1;
        end else begin
          tx_idx_n   = tx_idx + 3'd1;
          tx_shift_n = tx_shift >> 1;
          tx_n       = tx_shift[1];
        end
      end
      TX_STOP: if (tx_cnt == BIT_END) begin
        tx_cnt_n   = '0;
        tx_state_n = TX_IDLE;
        tx_n       = 1'b1;
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  assign busy = (tx_state != TX_IDLE);

  // ---------------- receiver ----------------
  logic rx_s, rx_q;

`ifdef BUART_RX_SYNC_EN
  inpin u_inpin (.clk(clk), .pin(rx), .rd(rx_s));
`else
  always_ff @(posedge clk) begin
    if (rst) rx_s <= 1'b1;
    else     rx_s <= rx;
  end
`endif

  rx_state_e            rx_state, rx_state_n;
  logic [CW-1:0]        rx_cnt, rx_cnt_n;
  logic [2:0]           rx_idx, rx_idx_n;
  logic [DATA_BITS-1:0] rx_shift, rx_shift_n;
  logic                 load;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_q     <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      valid    <= 1'b0;
    end else begin
      rx_q     <= rx_s;
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_idx   <= rx_idx_n;
      rx_shift <= rx_shift_n;
      // a new byte takes priority over an acknowledge in the same cycle
      if (load) begin
        rx_data <= rx_shift;
        valid   <= 1'b1;
      end else if (rd) begin
        valid   <= 1'b0;
      end
    end
  end

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt + CW'(1);
    rx_idx_n   = rx_idx;
    rx_shift_n = rx_shift;
    load       = 1'b0;
    unique case (rx_state)
      RX_IDLE: begin
        rx_cnt_n = '0;
        if (rx_q && !rx_s) rx_state_n = RX_START;
      end
      RX_START: if (rx_cnt == HALF_END) begin
        rx_cnt_n   = '0;
        rx_idx_n   = '0;
        rx_state_n = rx_s ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_cnt == BIT_END) begin
        rx_cnt_n   = '0;
        rx_shift_n = {rx_s, rx_shift[DATA_BITS-1:1]};
        if (rx_idx == LAST_BIT) rx_state_n = RX_STOP;
        else                    rx_idx_n   = rx_idx + 3'd1;
      end
      RX_STOP: if (rx_cnt == BIT_END) begin
        rx_cnt_n   = '0;
        rx_state_n = RX_IDLE;
        load       = rx_s;
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

endmodule

// File: tb/tb_buart.sv
// Directed self-checking bench for buart at 16 clocks per bit.
module tb_buart;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       tx;
  logic       rd;
  logic       wr;
  logic [7:0] tx_data;
  logic [7:0] rx_data;
  logic       valid;
  logic       busy;
  logic       rx_drv;
  logic       loop;

  int n_checks = 0;
  int n_fail   = 0;

  assign rx = loop ? tx : rx_drv;

  buart #(.CLKS_PER_BIT(16)) dut (
    .clk(clk), .rst(rst), .rx(rx), .tx(tx), .rd(rd), .wr(wr),
    .tx_data(tx_data), .rx_data(rx_data), .valid(valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic pulse_wr(input logic [7:0] d);
    wr = 1'b1; tx_data = d;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic pulse_rd();
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  // Drives one frame on rx; reports first cycle valid was seen and cycles valid was low.
  task automatic send_frame(input logic [7:0] d, input logic stopb,
                            output int first_valid, output int drops);
    logic [9:0] frame;
    frame = {stopb, d, 1'b0};
    first_valid = -1;
    drops = 0;
    for (int i = 0; i < 160; i++) begin
      rx_drv = frame[i / 16];
      @(negedge clk);
      if (valid && first_valid < 0) first_valid = i;
      if (!valid) drops++;
    end
    rx_drv = 1'b1;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, valid}, 32'd1);
  endtask

  task automatic wait_not_busy(input string tag);
    int n;
    n = 0;
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [9:0] frame_a5;
    logic [7:0] lb_bytes [3];
    int bcnt, fv, drops;

    rst = 1'b1; rd = 1'b0; wr = 1'b0; tx_data = '0; rx_drv = 1'b1; loop = 1'b0;
    idle(3);
    rst = 1'b0;
    @(negedge clk);
    check("rst_tx",      {31'd0, tx},    32'd1);
    check("rst_busy",    {31'd0, busy},  32'd0);
    check("rst_valid",   {31'd0, valid}, 32'd0);
    check("rst_rx_data", {24'd0, rx_data}, 32'h00);

    // TX 0xA5: line sequence 0,1,0,1,0,0,1,0,1,1; a mid-frame wr of 0x3C is ignored
    frame_a5 = 10'b1_1010_0101_0;
    pulse_wr(8'hA5);
    bcnt = 0;
    while (busy && bcnt < 400) begin
      if (bcnt < 160 && (bcnt % 16 == 0 || bcnt % 16 == 15))
        check($sformatf("tx_bit%0d_%0d", bcnt / 16, bcnt % 16), {31'd0, tx},
              {31'd0, frame_a5[bcnt / 16]});
      if (bcnt == 80) begin wr = 1'b1; tx_data = 8'h3C; end
      if (bcnt == 81) wr = 1'b0;
      bcnt++;
      @(negedge clk);
    end
    check("busy_len", bcnt, 160);
    check("tx_idle_after", {31'd0, tx}, 32'd1);
    idle(5);
    check("ignored_wr_no_frame", {31'd0, busy}, 32'd0);

    // Reset mid-frame aborts transmit
    pulse_wr(8'h00);
    idle(40);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_tx",   {31'd0, tx},   32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    idle(4);

    // RX 0x5A
    send_frame(8'h5A, 1'b1, fv, drops);
    check("rx5a_latency_ok", {31'd0, (fv >= 150 && fv <= 157)}, 32'd1);
    check("rx5a_valid", {31'd0, valid}, 32'd1);
    check("rx5a_data", {24'd0, rx_data}, 32'h5A);
    pulse_rd();
    check("rd_clears_valid", {31'd0, valid}, 32'd0);
    pulse_rd();
    check("rd_no_valid", {31'd0, valid}, 32'd0);
    check("rd_no_valid_data", {24'd0, rx_data}, 32'h5A);
    idle(10);

    // 4-cycle glitch
    rx_drv = 1'b0;
    idle(4);
    rx_drv = 1'b1;
    idle(200);
    check("glitch_valid", {31'd0, valid}, 32'd0);
    check("glitch_data", {24'd0, rx_data}, 32'h5A);

    // framing error
    send_frame(8'h33, 1'b0, fv, drops);
    idle(20);
    check("frame_err_valid", {31'd0, valid}, 32'd0);
    check("frame_err_data", {24'd0, rx_data}, 32'h5A);

    // overrun
    send_frame(8'h11, 1'b1, fv, drops);
    idle(2);
    check("ovr_first_data", {24'd0, rx_data}, 32'h11);
    send_frame(8'h22, 1'b1, fv, drops);
    idle(2);
    check("ovr_valid_drops", drops, 0);
    check("ovr_valid", {31'd0, valid}, 32'd1);
    check("ovr_data", {24'd0, rx_data}, 32'h22);
    pulse_rd();
    check("ovr_rd_clear", {31'd0, valid}, 32'd0);
    idle(10);

    // loopback, back-to-back frames
    loop = 1'b1;
    lb_bytes[0] = 8'hFF; lb_bytes[1] = 8'h00; lb_bytes[2] = 8'h81;
    pulse_wr(lb_bytes[0]);
    for (int k = 0; k < 3; k++) begin
      wait_valid($sformatf("lb%0d_valid", k));
      check($sformatf("lb%0d_data", k), {24'd0, rx_data}, {24'd0, lb_bytes[k]});
      pulse_rd();
      check($sformatf("lb%0d_rd_clear", k), {31'd0, valid}, 32'd0);
      wait_not_busy($sformatf("lb%0d_tx_done", k));
      if (k < 2) pulse_wr(lb_bytes[k + 1]);
    end
    idle(200);
    check("lb_no_extra_byte", {31'd0, valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/buart.md
# buart

Byte-oriented 8N1 UART transceiver with a registered receive holding byte and a single-shot transmit interface. It sits between the board RX/TX pins and the memory-mapped UART peripheral. The peripheral polls `valid` and `busy`, reads received bytes with an `rd` pulse, and launches transmits with a `wr` pulse. An optional two-flop input synchronizer (`inpin`) conditions the asynchronous RX pin.

## Interface

Parameters:
- `CLK_HZ`, default 12000000: system clock frequency.
- `BAUD`, default 115200: line rate.
- `CLKS_PER_BIT`, default `CLK_HZ/BAUD` (truncated): cycles per bit. Minimum legal value 4.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock, all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rx`  in  1  serial input, asynchronous, idle high.
- `tx`  out  1  serial output, idle high.
- `rd`  in  1  one-cycle pulse that acknowledges and clears `valid`.
- `wr`  in  1  one-cycle pulse that starts a transmit of `tx_data`.
- `tx_data`  in  8  byte to send, sampled on the cycle `wr` is accepted.
- `rx_data`  out  8  last received byte, held until overwritten.
- `valid`  out  1  `rx_data` holds an unacknowledged byte.
- `busy`  out  1  transmitter is sending a frame.

## Operation

- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). No parity.
- Transmitter states: IDLE, START, DATA (bit index 0..7), STOP.
  - `wr` in IDLE latches `tx_data` into a shift register and moves to START.
  - `wr` while `busy` is ignored, and the latched byte is unchanged.
- Receiver states: IDLE, START, DATA, STOP.
  - IDLE → START on a synchronized falling edge of `rx`.
  - START re-samples `rx` at CLKS_PER_BIT/2. If `rx` is high, treat it as a glitch and return to IDLE.
  - DATA samples the 8 bits, each CLKS_PER_BIT after the previous sample.
  - STOP samples the stop bit one CLKS_PER_BIT later:
    - Stop bit 1: load `rx_data` and set `valid`.
    - Stop bit 0 (framing error): discard the byte and leave `valid` and `rx_data` unchanged.
  - Return to IDLE after the stop sample. A new start edge is accepted from the next cycle.
- Overrun: a completed byte overwrites `rx_data` even if `valid` is already 1, and `valid` stays 1.
- `rd` with `valid`=0 has no effect. `rd` coinciding with a new byte load leaves `valid`=1 with the new byte (the load wins).
- Transmitter and receiver are fully independent, so full duplex works.

## Timing

- Reset values: `tx`=1, `busy`=0, `valid`=0, `rx_data`=0. Both state machines go to IDLE and all counters clear.
- Reset asserted mid-frame aborts the frame immediately: `tx` returns high on the next edge and no partial byte is delivered.
- Transmit latency, with `wr` accepted at edge N:
  - `busy`=1 and `tx`=0 from edge N+1.
  - Each bit is held exactly CLKS_PER_BIT cycles.
  - `busy` falls at edge N+1+10·CLKS_PER_BIT, i.e. after the full stop bit.
  - A `wr` on the same cycle `busy` falls is accepted, giving back-to-back frames.
- `valid` rises on the cycle after the mid-stop-bit sample. It clears on the edge after `rd` is seen.
- Synchronizer latency is 2 cycles with the macro defined and 1 cycle without.

## Configuration

- `BUART_RX_SYNC_EN`:
  - Defined: `rx` passes through `inpin`, a two-flop metastability synchronizer, before the receiver.
  - Undefined: `rx` passes through a single register only. Use this for inputs that are already synchronous or for simulation.

## Structure

- Shared package `buart_pkg`:
  - State enum typedefs for TX and RX.
  - Frame constants: data bits 8, frame bits 10.
  - Function computing CLKS_PER_BIT from CLK_HZ/BAUD.
- Sub-module `inpin` (ports `clk`, `pin`, `rd`): the synchronizer. Instantiated only under `BUART_RX_SYNC_EN`.
- Each direction needs one bit-period counter, sized to $clog2(CLKS_PER_BIT)+1 bits.

## Test plan

All scenarios use CLKS_PER_BIT=16.
- Reset: hold `rst` 3 cycles → `tx`=1, `busy`=0, `valid`=0, `rx_data`=0x00.
- TX 0xA5: pulse `wr` →
  - `tx` sequence 0,1,0,1,0,0,1,0,1,1, each bit held 16 cycles.
  - `busy` high for exactly 160 cycles.
  - A second `wr` with 0x3C issued mid-frame is ignored.
- RX 0x5A: drive a frame on `rx` →
  - `valid`=1 and `rx_data`=0x5A about 152 cycles after the start edge.
  - `rd` pulse → `valid`=0 on the next cycle.
- Glitch and framing error:
  - 4-cycle low pulse on `rx` → no byte.
  - Frame 0x33 with stop=0 → `valid` stays 0.
- Overrun: send 0x11 then 0x22 without `rd` → `rx_data`=0x22 and `valid`=1 throughout.
- Loopback: tie `tx` to `rx`, send 0xFF, 0x00 and 0x81 back-to-back → each is received intact with matching `valid` pulses.
